// File: rtl/adc_interface_apb_if.sv
// APB bus bundle shared by the ADC/DAC slaves.
// Single-register slaves: address, write data and strobes travel but may be ignored.
interface adc_interface_apb_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/adc_interface_apb.sv
// APB slave that runs one ADC conversion per read and returns the sample.
// EOC timeout completes the read with PSLVERR; writes are acked without effect.
module adc_interface_apb #(
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 63
) (
    input  logic              CLK,
    input  logic              RST,
    adc_interface_apb_if.slave bus,
    output logic              SOC,
    input  logic              EOC,
    input  logic [DATA_W-1:0] ADC_DATA
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] WAIT_EOC = 3'd2;
    localparam logic [2:0] RREADY   = 3'd3;
    localparam logic [2:0] WACK     = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              err_q, err_d;
    logic              acc;
    logic              unused;

    assign acc    = bus.PSEL & bus.PENABLE;
    assign unused = ^{bus.PADDR, bus.PWDATA, bus.PSTRB};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (acc) state_d = bus.PWRITE ? WACK : START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_EOC;
            end
            WAIT_EOC: begin
                // A late EOC still beats the timeout in the same cycle
                if (EOC) begin
                    sample_d = ADC_DATA;
                    err_d    = 1'b0;
                    state_d  = RREADY;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    sample_d = '0;
                    err_d    = 1'b1;
                    state_d  = RREADY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RREADY:  state_d = IDLE;
            WACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sample_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            err_q    <= err_d;
        end
    end

    assign SOC         = (state_q == START);
    assign bus.PREADY  = (state_q == RREADY) | (state_q == WACK);
    assign bus.PSLVERR = (state_q == RREADY) & err_q;
    assign bus.PRDATA  = (state_q == RREADY)
                       ? {{(32-DATA_W){1'b0}}, sample_q}
                       : 32'h0;
endmodule

// File: tb/tb_adc_interface_apb.sv
// Randomized bench for adc_interface_apb against a transaction-level model.
// Inputs driven and outputs sampled on the falling edge.
module tb_adc_interface_apb;
    localparam int DW  = 12;
    localparam int TMO = 63;

    logic          clk;
    logic          rst;
    logic          soc;
    logic          eoc;
    logic [DW-1:0] adc;
    int            checks;
    int            failures;

    adc_interface_apb_if bus();

    adc_interface_apb #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave),
        .SOC(soc),
        .EOC(eoc),
        .ADC_DATA(adc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_bus();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    // d = WAIT cycles with EOC low before EOC rises (EOC in WAIT cycle d+1)
    task automatic do_read(input int d, input bit drop, input bit keep,
                           input bit stray, input bit use_fix,
                           input logic [DW-1:0] fix);
        int k;
        bit done;
        bit exp_err;
        int exp_n;
        logic [DW-1:0] cap;
        logic [31:0] exp_rd;
        exp_err = (d > TMO);
        exp_n   = exp_err ? TMO + 1 : d + 1;
        cap     = '0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = $urandom;
        bus.PWDATA  = $urandom;
        eoc = stray;
        adc = DW'($urandom);
        @(negedge clk);
        checks++;
        if (soc !== 1'b1 || bus.PREADY !== 1'b0) begin
            failures++;
            $display("FAIL soc_start soc=%b pready=%b want soc=1 pready=0",
                     soc, bus.PREADY);
        end
        if (drop) begin
            bus.PSEL    = 1'b0;
            bus.PENABLE = 1'b0;
        end
        eoc = stray;
        adc = DW'($urandom);
        k = 0;
        done = 0;
        while (!done && k < TMO + 20) begin
            @(negedge clk);
            if (bus.PREADY === 1'b1) begin
                done = 1;
            end else begin
                k++;
                if (soc !== 1'b0) begin
                    checks++;
                    failures++;
                    $display("FAIL soc_single soc=%b in wait cycle %0d want 0",
                             soc, k);
                end
                eoc = (k == d + 1);
                adc = use_fix ? fix : DW'($urandom);
                if (k == d + 1) cap = adc;
            end
        end
        exp_rd = exp_err ? 32'h0 : {{(32-DW){1'b0}}, cap};
        checks++;
        if (!done || k != exp_n) begin
            failures++;
            $display("FAIL latency done=%0d wait_cycles=%0d want %0d (d=%0d)",
                     done, k, exp_n, d);
        end
        checks++;
        if (bus.PRDATA !== exp_rd || bus.PSLVERR !== exp_err) begin
            failures++;
            $display("FAIL rdata prdata=%h slverr=%b want %h %b (d=%0d)",
                     bus.PRDATA, bus.PSLVERR, exp_rd, exp_err, d);
        end
        eoc = 1'b0;
        if (!keep) begin
            idle_bus();
            @(negedge clk);
            checks++;
            if (bus.PREADY !== 1'b0 || bus.PRDATA !== 32'h0 || soc !== 1'b0) begin
                failures++;
                $display("FAIL after_read pready=%b prdata=%h soc=%b want 0 0 0",
                         bus.PREADY, bus.PRDATA, soc);
            end
        end
    endtask

    task automatic do_write();
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        bus.PWRITE  = 1'b1;
        bus.PWDATA  = 32'hFFFF_FFFF;
        bus.PSTRB   = 4'hF;
        @(negedge clk);
        checks++;
        if (bus.PREADY !== 1'b1 || bus.PRDATA !== 32'h0 ||
            bus.PSLVERR !== 1'b0 || soc !== 1'b0) begin
            failures++;
            $display("FAIL write_ack pready=%b prdata=%h slverr=%b soc=%b want 1 0 0 0",
                     bus.PREADY, bus.PRDATA, bus.PSLVERR, soc);
        end
        idle_bus();
        @(negedge clk);
        checks++;
        if (bus.PREADY !== 1'b0 || soc !== 1'b0) begin
            failures++;
            $display("FAIL write_after pready=%b soc=%b want 0 0", bus.PREADY, soc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        bus.PSTRB   = '0;
        eoc = 1'b0;
        adc = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.PREADY !== 1'b0 || soc !== 1'b0 ||
                bus.PRDATA !== 32'h0 || bus.PSLVERR !== 1'b0) begin
                failures++;
                $display("FAIL reset pready=%b soc=%b prdata=%h slverr=%b want 0",
                         bus.PREADY, soc, bus.PRDATA, bus.PSLVERR);
            end
        end
        idle_bus();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        do_read(3, 0, 0, 0, 1, 12'hA5C);
        for (int i = 0; i < 4; i++) do_read(i, 0, 0, 0, 0, '0);
    endtask

    task automatic test_timeout();
        do_read(TMO + 1, 0, 0, 0, 0, '0);
        do_read(TMO, 0, 0, 0, 0, '0);
        do_read(300, 0, 0, 0, 0, '0);
    endtask

    task automatic test_write();
        do_write();
        do_read(2, 0, 0, 0, 0, '0);
    endtask

    task automatic test_reset_mid();
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        bus.PWRITE  = 1'b0;
        @(negedge clk);
        idle_bus();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        eoc = 1'b1;
        adc = 12'h7E1;
        @(negedge clk);
        rst = 1'b0;
        eoc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus.PREADY !== 1'b0 || soc !== 1'b0 || bus.PRDATA !== 32'h0) begin
                failures++;
                $display("FAIL reset_mid pready=%b soc=%b prdata=%h want 0 0 0",
                         bus.PREADY, soc, bus.PRDATA);
            end
        end
        do_read(1, 0, 0, 0, 1, 12'h3C9);
    endtask

    task automatic test_stray();
        eoc = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.PREADY !== 1'b0 || soc !== 1'b0) begin
            failures++;
            $display("FAIL stray_idle pready=%b soc=%b want 0 0", bus.PREADY, soc);
        end
        do_read(5, 1, 0, 1, 0, '0);
        do_read(0, 1, 0, 1, 0, '0);
    endtask

    task automatic test_back_to_back();
        do_read(2, 0, 1, 0, 0, '0);
        @(negedge clk);
        checks++;
        if (soc !== 1'b0 || bus.PREADY !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap soc=%b pready=%b want 0 0", soc, bus.PREADY);
        end
        do_read(4, 0, 0, 0, 0, '0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_write();
            end else begin
                do_read(($urandom_range(0, 7) == 0) ? $urandom_range(60, 80)
                                                    : $urandom_range(0, 12),
                        1'($urandom), 0, 1'($urandom), 0, '0);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_read();
        test_timeout();
        test_write();
        test_reset_mid();
        test_stray();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
